// File: rtl/rr_encoder_arb.sv
// rr_encoder_arb: registered round-robin request encoder with a valid/ready grant; define RR_ENCODER_ARB_LOCK_EN to add the lock input
module rr_encoder_arb #(
    parameter int N = 2,
    localparam int M = 2**N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] req,
    input  logic         gnt_ready,
`ifdef RR_ENCODER_ARB_LOCK_EN
    input  logic         lock,
`endif
    output logic         gnt_valid,
    output logic [N-1:0] gnt_idx,
    output logic [M-1:0] gnt_onehot,
    output logic         any_req
);
    localparam logic [0:0] IDLE = 1'b0, GRANT = 1'b1;
    logic [0:0]   state;
    logic [N-1:0] ptr, base, sel, nxt_idx;
    logic         hold_ptr, take;
`ifdef RR_ENCODER_ARB_LOCK_EN
    assign hold_ptr = lock;
`else
    assign hold_ptr = 1'b0;
`endif
    assign any_req   = |req;
    assign gnt_valid = state == GRANT;
    assign take      = !gnt_valid || gnt_ready;
    // base is also the ptr value committed on a handshake
    assign base      = (gnt_valid && !hold_ptr) ? gnt_idx + N'(1) : ptr;
    assign nxt_idx   = (gnt_valid && hold_ptr && req[gnt_idx]) ? gnt_idx : sel;
    // descending scan so the lowest offset from base wins
    always_comb begin
        sel = '0;
        for (int i = M - 1; i >= 0; i--)
            sel = req[base + N'(i)] ? base + N'(i) : sel;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else if (take) begin
            if (gnt_valid) ptr <= base;
            state      <= any_req ? GRANT : IDLE;
            gnt_idx    <= any_req ? nxt_idx : gnt_idx;
            gnt_onehot <= any_req ? M'(1) << nxt_idx : '0;
        end
    end
endmodule

// File: tb/tb_rr_encoder_arb.sv
// tb_rr_encoder_arb: directed and random checks of rr_encoder_arb against a scoreboarded reference model
module tb_rr_encoder_arb;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       gnt_ready = 1'b0;
    logic       lock = 1'b0;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic [3:0] gnt_onehot;
    logic       any_req;

    int errors = 0;
    int checks = 0;

    logic [6:0] sb[$];
    logic       m_valid = 1'b0;
    int         m_idx = 0;
    int         m_ptr = 0;

`ifdef RR_ENCODER_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    rr_encoder_arb #(.N(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt_ready(gnt_ready),
`ifdef RR_ENCODER_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx),
        .gnt_onehot(gnt_onehot),
        .any_req(any_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [3:0] r);
        int pick = -1;
        for (int i = 0; i < 4; i++)
            if (pick < 0 && r[(p + i) % 4]) pick = (p + i) % 4;
        return pick;
    endfunction

    task automatic step(input logic [3:0] r, input logic rdy);
        logic [6:0] exp;
        logic       lk;
        @(negedge clk);
        req = r;
        gnt_ready = rdy;
        #1;
        check("any_req", any_req, |r);
        lk = LOCK_ON && lock;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_idx = 0;
            m_ptr = 0;
        end else if (!m_valid || rdy) begin
            int pick;
            if (m_valid && !lk) m_ptr = (m_idx + 1) % 4;
            pick = (m_valid && lk && r[m_idx]) ? m_idx : rr_pick(m_ptr, r);
            m_valid = r != 0;
            if (m_valid) m_idx = pick;
        end
        exp = {m_valid, 2'(m_idx), m_valid ? 4'(1 << m_idx) : 4'b0};
        sb.push_back(exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) check("sb_empty", 0, 1);
        else begin
            exp = sb.pop_front();
            check("sb_valid", gnt_valid, exp[6]);
            if (exp[6]) check("sb_idx", gnt_idx, exp[5:4]);
            check("sb_onehot", gnt_onehot, exp[3:0]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(4'b0000, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step(4'b1111, 1'b0);
            check("rst_valid", gnt_valid, 0);
            check("rst_idx", gnt_idx, 0);
            check("rst_onehot", gnt_onehot, 0);
        end
        rst_n = 1'b1;

        step(4'b0100, 1'b0);
        check("lat_valid", gnt_valid, 1);
        check("lat_idx", gnt_idx, 2);
        check("lat_onehot", gnt_onehot, 4'b0100);
        step(4'b0000, 1'b1);
        check("lat_idle", gnt_valid, 0);

        do_reset();
        step(4'b1111, 1'b0);
        check("rot0", gnt_idx, 0);
        step(4'b1111, 1'b1);
        check("rot1", gnt_idx, 1);
        step(4'b1111, 1'b1);
        check("rot2", gnt_idx, 2);
        step(4'b1111, 1'b1);
        check("rot3", gnt_idx, 3);
        step(4'b1111, 1'b1);
        check("rot4", gnt_idx, 0);
        step(4'b0000, 1'b1);
        check("rot_idle", gnt_valid, 0);

        step(4'b0010, 1'b0);
        check("hold_first", gnt_idx, 1);
        for (int k = 0; k < 5; k++) begin
            step(4'b1000, 1'b0);
            check("hold_idx", gnt_idx, 1);
            check("hold_valid", gnt_valid, 1);
        end
        step(4'b1000, 1'b1);
        check("hold_next", gnt_idx, 3);
        step(4'b0000, 1'b1);
        check("hold_idle", gnt_valid, 0);

        step(4'b0100, 1'b0);
        check("wrap_g2", gnt_idx, 2);
        step(4'b1001, 1'b1);
        check("wrap_g3", gnt_idx, 3);
        step(4'b1001, 1'b1);
        check("wrap_g0", gnt_idx, 0);
        step(4'b1001, 1'b1);
        check("wrap_g3b", gnt_idx, 3);
        step(4'b0000, 1'b1);

`ifdef RR_ENCODER_ARB_LOCK_EN
        do_reset();
        step(4'b0011, 1'b0);
        check("lock_g0", gnt_idx, 0);
        lock = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(4'b0011, 1'b1);
            check("lock_hold", gnt_idx, 0);
        end
        lock = 1'b0;
        step(4'b0011, 1'b1);
        check("lock_release", gnt_idx, 1);
        step(4'b0000, 1'b1);
`endif

        for (int k = 0; k < 400; k++) begin
            rst_n = $urandom_range(0, 39) != 0;
            lock = $urandom_range(0, 3) == 0;
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        rst_n = 1'b1;
        lock = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
